// File: rtl/decoder_2to4_seq_if.sv
// Request/response bundle for the handshaked binary-to-one-hot decoder.
// The requester uses the master modport and the decoder uses the slave modport.
interface decoder_2to4_seq_if #(
  parameter int N = 2
);
  localparam int W = 1 << N;

  logic [N-1:0] A;
  logic         E;
  logic         valid;
  logic         ready;
  logic [W-1:0] O;
  logic         busy;
  logic         done;

  modport master (
    output A, E, valid,
    input  ready, O, busy, done
  );

  modport slave (
    input  A, E, valid,
    output ready, O, busy, done
  );
endinterface

// File: rtl/decoder_2to4_seq.sv
// Registered binary-to-one-hot decoder. It holds one line high for HOLD cycles
// after each enabled request and then pulses done for one cycle.
module decoder_2to4_seq #(
  parameter int N    = 2,
  parameter int HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  decoder_2to4_seq_if.slave bus
);
  localparam int         W       = 1 << N;
  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t       state_q;
  logic [7:0]   cnt_q;
  logic [W-1:0] o_q;
  logic         busy_q;
  logic         done_q;
  logic [W-1:0] onehot_d;

  always_comb begin
    onehot_d        = '0;
    onehot_d[bus.A] = 1'b1;
  end

  // The counter starts at HOLD-1 and stops at zero, so it never wraps.
  // The last DRIVE cycle is the one in which the counter reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      o_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          o_q    <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.valid) begin
            if (bus.E) begin
              o_q     <= onehot_d;
              busy_q  <= 1'b1;
              cnt_q   <= HOLD_M1;
              state_q <= DRIVE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        DRIVE: begin
          if (cnt_q == 8'd0) begin
            o_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          o_q     <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.O     = o_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule
